// File: rtl/vga_pkg.sv
// vga_pkg: XGA timing defaults, 12-bit pixel type and test-pattern
// bar colors shared by the video output stage.
package vga_pkg;

  localparam int XGA_H_ACTIVE = 1024;
  localparam int XGA_H_FP     = 24;
  localparam int XGA_H_SYNC   = 136;
  localparam int XGA_H_BP     = 160;
  localparam int XGA_V_ACTIVE = 768;
  localparam int XGA_V_FP     = 3;
  localparam int XGA_V_SYNC   = 6;
  localparam int XGA_V_BP     = 29;

  localparam int HCNT_W = 11;
  localparam int VCNT_W = 10;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb12_t;

  typedef struct packed {
    logic blank;
    logic hs;
    logic vs;
    logic fs;
  } tctl_t;

  // Bar 0 sits in the low slot, bar 7 in the high slot.
  localparam logic [7:0][11:0] BAR_RGB = {
    12'h000, 12'h00F, 12'hF00, 12'hF0F,
    12'h0F0, 12'h0FF, 12'hFF0, 12'hFFF
  };

  function automatic rgb12_t bar_color(input logic [2:0] idx);
    return rgb12_t'(BAR_RGB[idx]);
  endfunction

endpackage

// File: rtl/delay_line.sv
// delay_line: DEPTH-stage shift register; the synchronous active-low
// reset loads every stage with RESET_VAL.
module delay_line #(
  parameter int               WIDTH     = 1,
  parameter int               DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [DEPTH*WIDTH-1:0] sr_q, sr_d;

  always_comb begin
    sr_d = sr_q << WIDTH;
    sr_d[WIDTH-1:0] = d_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sr_q <= {DEPTH{RESET_VAL}};
    end else begin
      sr_q <= sr_d;
    end
  end

  assign q_o = sr_q[DEPTH*WIDTH-1 -: WIDTH];

endmodule

// File: rtl/vga_out.sv
// vga_out: raster counters plus registered, blank-masked RGB and syncs.
// VGA_TEST_PATTERN_EN adds pattern_sel_in and an 8-bar color pattern.
module vga_out
  import vga_pkg::*;
#(
  parameter int H_ACTIVE   = XGA_H_ACTIVE,
  parameter int H_FP       = XGA_H_FP,
  parameter int H_SYNC     = XGA_H_SYNC,
  parameter int H_BP       = XGA_H_BP,
  parameter int V_ACTIVE   = XGA_V_ACTIVE,
  parameter int V_FP       = XGA_V_FP,
  parameter int V_SYNC     = XGA_V_SYNC,
  parameter int V_BP       = XGA_V_BP,
  parameter bit SYNC_POL   = 1'b0,
  parameter int PIPE_DELAY = 4
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  output logic [HCNT_W-1:0] hcount_out,
  output logic [VCNT_W-1:0] vcount_out,
  input  logic [11:0]       pixel_in,
`ifdef VGA_TEST_PATTERN_EN
  input  logic              pattern_sel_in,
`endif
  output logic [3:0]        vga_r,
  output logic [3:0]        vga_g,
  output logic [3:0]        vga_b,
  output logic              vga_hs,
  output logic              vga_vs,
  output logic              frame_start_out
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_BEG  = H_ACTIVE + H_FP;
  localparam int HS_END  = HS_BEG + H_SYNC;
  localparam int VS_BEG  = V_ACTIVE + V_FP;
  localparam int VS_END  = VS_BEG + V_SYNC;

  localparam tctl_t CTL_RST = '{
    blank: 1'b1, hs: 1'b0, vs: 1'b0, fs: 1'b0
  };

`ifdef VGA_TEST_PATTERN_EN
  localparam int BAR_W = H_ACTIVE / 8;
  localparam int DW    = $bits(tctl_t) + HCNT_W;
  localparam logic [DW-1:0] DL_RST = {CTL_RST, HCNT_W'(0)};
`else
  localparam int DW    = $bits(tctl_t);
  localparam logic [DW-1:0] DL_RST = CTL_RST;
`endif

  logic [HCNT_W-1:0] hcnt_q, hcnt_d;
  logic [VCNT_W-1:0] vcnt_q, vcnt_d;
  tctl_t             ctl_raw, ctl_dly;
  logic [DW-1:0]     dl_d, dl_q;
  rgb12_t            rgb_q, rgb_d;
  logic              hs_q, hs_d;
  logic              vs_q, vs_d;
  logic              fs_q, fs_d;

  always_comb begin
    hcnt_d = hcnt_q + HCNT_W'(1);
    vcnt_d = vcnt_q;
    if (hcnt_q == HCNT_W'(H_TOTAL - 1)) begin
      hcnt_d = '0;
      if (vcnt_q == VCNT_W'(V_TOTAL - 1)) begin
        vcnt_d = '0;
      end else begin
        vcnt_d = vcnt_q + VCNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
    end else begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
    end
  end

  always_comb begin
    ctl_raw.blank = (hcnt_q >= HCNT_W'(H_ACTIVE)) ||
                    (vcnt_q >= VCNT_W'(V_ACTIVE));
    ctl_raw.hs    = (hcnt_q >= HCNT_W'(HS_BEG)) &&
                    (hcnt_q <  HCNT_W'(HS_END));
    ctl_raw.vs    = (vcnt_q >= VCNT_W'(VS_BEG)) &&
                    (vcnt_q <  VCNT_W'(VS_END));
    ctl_raw.fs    = (hcnt_q == '0) && (vcnt_q == '0);
  end

`ifdef VGA_TEST_PATTERN_EN
  logic [HCNT_W-1:0] hcnt_dly;
  assign dl_d = {ctl_raw, hcnt_q};
  assign {ctl_dly, hcnt_dly} = dl_q;
`else
  assign dl_d    = ctl_raw;
  assign ctl_dly = tctl_t'(dl_q);
`endif

  // Timing travels alongside the upstream pixel pipeline.
  delay_line #(
    .WIDTH     (DW),
    .DEPTH     (PIPE_DELAY),
    .RESET_VAL (DL_RST)
  ) u_dly (
    .clk_i  (clk_in),
    .rst_ni (rst_n_in),
    .d_i    (dl_d),
    .q_o    (dl_q)
  );

  always_comb begin
    rgb_d = '0;
    if (!ctl_dly.blank) begin
      rgb_d = rgb12_t'(pixel_in);
`ifdef VGA_TEST_PATTERN_EN
      if (pattern_sel_in) begin
        rgb_d = bar_color(3'(hcnt_dly / HCNT_W'(BAR_W)));
      end
`endif
    end
    hs_d = ctl_dly.hs ? SYNC_POL : ~SYNC_POL;
    vs_d = ctl_dly.vs ? SYNC_POL : ~SYNC_POL;
    fs_d = ctl_dly.fs;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      rgb_q <= '0;
      hs_q  <= ~SYNC_POL;
      vs_q  <= ~SYNC_POL;
      fs_q  <= 1'b0;
    end else begin
      rgb_q <= rgb_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      fs_q  <= fs_d;
    end
  end

  assign hcount_out      = hcnt_q;
  assign vcount_out      = vcnt_q;
  assign vga_r           = rgb_q.r;
  assign vga_g           = rgb_q.g;
  assign vga_b           = rgb_q.b;
  assign vga_hs          = hs_q;
  assign vga_vs          = vs_q;
  assign frame_start_out = fs_q;

endmodule

// File: tb/tb_vga_out.sv
// tb_vga_out: three vga_out instances (XGA, small raster, small raster
// with active-high sync and one-cycle pipe) against a raster model.
module tb_vga_out;

  typedef struct packed {
    int ha; int hf; int hs; int hb;
    int va; int vf; int vs; int vb;
    int pol; int d;
  } cfg_t;

  localparam cfg_t C0 = '{1024, 24, 136, 160, 768, 3, 6, 29, 0, 4};
  localparam cfg_t C1 = '{32, 4, 6, 6, 16, 2, 3, 3, 0, 4};
  localparam cfg_t C2 = '{32, 4, 6, 6, 16, 2, 3, 3, 1, 1};

  cfg_t cfg [3];

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] px  [3];
  logic        sel [3];
  logic        sh  [3];
  logic [10:0] hc  [3];
  logic [9:0]  vc  [3];
  logic [3:0]  r   [3];
  logic [3:0]  g   [3];
  logic [3:0]  b   [3];
  logic        hs  [3];
  logic        vs  [3];
  logic        fs  [3];

  int nchk = 0;
  int nfail = 0;
  int k = 0;
  bit started = 0;
  bit meas = 0;
  int hs_first = -1;
  int hs_len = 0;
  int vs_b = 0;
  int vs_c = 0;

  always #5 clk = ~clk;

  vga_out u_a (
    .clk_in(clk), .rst_n_in(rst_n),
    .hcount_out(hc[0]), .vcount_out(vc[0]),
    .pixel_in(px[0]),
`ifdef VGA_TEST_PATTERN_EN
    .pattern_sel_in(sel[0]),
`endif
    .vga_r(r[0]), .vga_g(g[0]), .vga_b(b[0]),
    .vga_hs(hs[0]), .vga_vs(vs[0]),
    .frame_start_out(fs[0])
  );

  vga_out #(
    .H_ACTIVE(32), .H_FP(4), .H_SYNC(6), .H_BP(6),
    .V_ACTIVE(16), .V_FP(2), .V_SYNC(3), .V_BP(3)
  ) u_b (
    .clk_in(clk), .rst_n_in(rst_n),
    .hcount_out(hc[1]), .vcount_out(vc[1]),
    .pixel_in(px[1]),
`ifdef VGA_TEST_PATTERN_EN
    .pattern_sel_in(sel[1]),
`endif
    .vga_r(r[1]), .vga_g(g[1]), .vga_b(b[1]),
    .vga_hs(hs[1]), .vga_vs(vs[1]),
    .frame_start_out(fs[1])
  );

  vga_out #(
    .H_ACTIVE(32), .H_FP(4), .H_SYNC(6), .H_BP(6),
    .V_ACTIVE(16), .V_FP(2), .V_SYNC(3), .V_BP(3),
    .SYNC_POL(1'b1), .PIPE_DELAY(1)
  ) u_c (
    .clk_in(clk), .rst_n_in(rst_n),
    .hcount_out(hc[2]), .vcount_out(vc[2]),
    .pixel_in(px[2]),
`ifdef VGA_TEST_PATTERN_EN
    .pattern_sel_in(sel[2]),
`endif
    .vga_r(r[2]), .vga_g(g[2]), .vga_b(b[2]),
    .vga_hs(hs[2]), .vga_vs(vs[2]),
    .frame_start_out(fs[2])
  );

  function automatic int htot(cfg_t c);
    return c.ha + c.hf + c.hs + c.hb;
  endfunction

  function automatic int vtot(cfg_t c);
    return c.va + c.vf + c.vs + c.vb;
  endfunction

  function automatic logic [11:0] echo(int h, int v);
    logic [10:0] hh;
    logic [9:0]  vv;
    hh = 11'(h);
    vv = 10'(v);
    return {hh[3:0], vv[3:0], 4'hA};
  endfunction

  function automatic logic [11:0] bar(int i);
    case (i)
      0: return 12'hFFF;
      1: return 12'hFF0;
      2: return 12'h0FF;
      3: return 12'h0F0;
      4: return 12'hF0F;
      5: return 12'hF00;
      6: return 12'h00F;
      default: return 12'h000;
    endcase
  endfunction

  function automatic logic [20:0] exp_cnt(cfg_t c, int n);
    int h, v;
    h = n % htot(c);
    v = (n / htot(c)) % vtot(c);
    return {10'(v), 11'(h)};
  endfunction

  // Upstream echo: pixel for the count issued d cycles ago; noise if blank.
  function automatic logic [11:0] pix(cfg_t c, int n);
    int h, v;
    if (n < c.d) return 12'($urandom);
    h = (n - c.d) % htot(c);
    v = ((n - c.d) / htot(c)) % vtot(c);
    if (h < c.ha && v < c.va) return echo(h, v);
    return 12'($urandom);
  endfunction

  function automatic logic [14:0] exp_out(cfg_t c, int n, logic s);
    int h, v;
    logic p, ha, va, f;
    logic [11:0] rgb;
    p = (c.pol != 0);
    if (n < c.d + 1) return {~p, ~p, 1'b0, 12'h000};
    h = (n - c.d - 1) % htot(c);
    v = ((n - c.d - 1) / htot(c)) % vtot(c);
    ha = (h >= c.ha + c.hf) && (h < c.ha + c.hf + c.hs);
    va = (v >= c.va + c.vf) && (v < c.va + c.vf + c.vs);
    f = (h == 0) && (v == 0);
    rgb = 12'h000;
    if (h < c.ha && v < c.va) begin
      rgb = s ? bar(h / (c.ha / 8)) : echo(h, v);
    end
    return {ha ? p : ~p, va ? p : ~p, f, rgb};
  endfunction

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input logic rv);
    rst_n = rv;
    for (int i = 0; i < 3; i++) begin
      px[i] = pix(cfg[i], k);
`ifdef VGA_TEST_PATTERN_EN
      sel[i] = 1'($urandom_range(1, 0));
`endif
    end
    @(negedge clk);
    if (started) begin
      for (int i = 0; i < 3; i++) begin
        check($sformatf("cnt%0d k=%0d", i, k),
              32'({vc[i], hc[i]}),
              32'(exp_cnt(cfg[i], k)));
        check($sformatf("out%0d k=%0d", i, k),
              32'({hs[i], vs[i], fs[i], r[i], g[i], b[i]}),
              32'(exp_out(cfg[i], k, sh[i])));
      end
      if (meas && k < 1344 && !hs[0]) begin
        if (hs_first < 0) hs_first = k;
        hs_len++;
      end
      if (meas && k < 1152) begin
        if (!vs[1]) vs_b++;
        if (vs[2]) vs_c++;
      end
    end
    @(posedge clk);
    for (int i = 0; i < 3; i++) sh[i] = sel[i];
    if (!rst_n) begin
      k = 0;
      started = 1;
    end else begin
      k++;
    end
    #1;
  endtask

  initial begin
    cfg[0] = C0;
    cfg[1] = C1;
    cfg[2] = C2;
    for (int i = 0; i < 3; i++) begin
      px[i] = '0;
      sel[i] = 1'b0;
      sh[i] = 1'b0;
    end
    repeat (3) tick(1'b0);
    meas = 1;
    repeat (2700) tick(1'b1);
    meas = 0;
    check("xga_hs_start", 32'(hs_first), 32'd1053);
    check("xga_hs_len", 32'(hs_len), 32'd136);
    check("small_vs_low", 32'(vs_b), 32'd144);
    check("pol1_vs_high", 32'(vs_c), 32'd144);
    for (int n = 0; n < 5; n++) begin
      repeat ($urandom_range(1500, 200)) tick(1'b1);
      repeat ($urandom_range(2, 1)) tick(1'b0);
    end
    repeat (2400) tick(1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

endmodule
